rf_write_buffer: RTL

- Write-side front end for the 4x16 register file; owns the file's single write port (write, addr3, data3).
- Accepts writeback requests from two producers with valid/ready handshakes: EX (ALU result) and MEM (load result).
- Queues requests in a small in-order FIFO and drains one entry per cycle onto the RF write port, unless held.
- Provides bypass data for the two RF read addresses so readers never see a stale value while a write is pending.

---
 rtl/rf_write_buffer_pkg.sv | 19 +
 rtl/rf_write_buffer_if.sv | 64 ++++++
 rtl/rf_write_buffer_wb_fifo.sv | 82 ++++++++
 rtl/rf_write_buffer.sv | 100 ++++++++++
 4 files changed

// File: rtl/rf_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rf_write_buffer_pkg
// Shared register-file geometry and the writeback entry type used by the
// write buffer, its FIFO and its interface.
// -----------------------------------------------------------------------------
package rf_write_buffer_pkg;

   localparam int REG_AW       = 2;   // register address width
   localparam int WORD_W       = 16;  // register width
   localparam int NUM_REGS     = 4;   // registers in the file
   localparam int NUM_RD_PORTS = 2;   // RF read ports that need bypass

   // One pending register-file write.
   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [WORD_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_write_buffer_if.sv
// -----------------------------------------------------------------------------
// rf_write_buffer_if
// Bundles the write buffer's producer handshakes (EX, MEM), drain control,
// RF write-port drive, bypass lookups and status.
//   slave  : the write buffer side (accepts requests, drives RF / bypass)
//   master : the surrounding pipeline side
// -----------------------------------------------------------------------------
interface rf_write_buffer_if
   import rf_write_buffer_pkg::*;
#(
   parameter int AW = REG_AW,
   parameter int DW = WORD_W
);

   // EX producer
   logic          ex_valid;
   logic [AW-1:0] ex_addr;
   logic [DW-1:0] ex_data;
   logic          ex_ready;
   // MEM producer
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_ready;
   // drain control and RF write port
   logic          wb_hold;
   logic          rf_write;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   // bypass lookups
   logic [AW-1:0] rd_addr1;
   logic [AW-1:0] rd_addr2;
   logic          byp_hit1;
   logic [DW-1:0] byp_data1;
   logic          byp_hit2;
   logic [DW-1:0] byp_data2;
   // status
   logic          empty;

   modport slave (
      input  ex_valid, ex_addr, ex_data,
      output ex_ready,
      input  mem_valid, mem_addr, mem_data,
      output mem_ready,
      input  wb_hold,
      output rf_write, rf_addr, rf_data,
      input  rd_addr1, rd_addr2,
      output byp_hit1, byp_data1, byp_hit2, byp_data2,
      output empty
   );

   modport master (
      output ex_valid, ex_addr, ex_data,
      input  ex_ready,
      output mem_valid, mem_addr, mem_data,
      input  mem_ready,
      output wb_hold,
      input  rf_write, rf_addr, rf_data,
      output rd_addr1, rd_addr2,
      input  byp_hit1, byp_data1, byp_hit2, byp_data2,
      input  empty
   );

endinterface

// File: rtl/rf_write_buffer_wb_fifo.sv
// -----------------------------------------------------------------------------
// rf_write_buffer_wb_fifo
// In-order storage for pending register writes.
//   clk, reset_n : clock, synchronous active-low reset
//   push, push_entry : write one entry at the tail
//   pop              : retire the head entry
//   head             : oldest entry
//   entries, valid   : raw storage and per-slot occupancy for bypass scans
//   rd_ptr, count    : head slot index and occupancy
// Push and pop in the same cycle are both honoured, including when full.
// -----------------------------------------------------------------------------
module rf_write_buffer_wb_fifo
   import rf_write_buffer_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        push,
   input  wb_entry_t                   push_entry,
   input  logic                        pop,
   output wb_entry_t                   head,
   output wb_entry_t [DEPTH-1:0]       entries,
   output logic      [DEPTH-1:0]       valid,
   output logic      [PW-1:0]          rd_ptr,
   output logic      [CW-1:0]          count
);

   wb_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic      [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic      [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic      [CW-1:0]    count_q, count_d;

   // Pointers are log2(DEPTH) wide, so +1 wraps modulo DEPTH for free.
   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         entries_d[wr_ptr_q] = push_entry;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         entries_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // A slot is occupied when its distance from the head is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_vld
      logic [PW-1:0] off;
      assign off      = PW'(i) - rd_ptr_q;
      assign valid[i] = (CW'(off) < count_q);
   end

   assign head    = entries_q[rd_ptr_q];
   assign entries = entries_q;
   assign rd_ptr  = rd_ptr_q;
   assign count   = count_q;

endmodule

// File: rtl/rf_write_buffer.sv
// -----------------------------------------------------------------------------
// rf_write_buffer
// Write-side front end of the 4x16 register file. Accepts writebacks from
// EX and MEM, queues them in order, drains one per cycle onto the RF write
// port unless held, and supplies bypass data for the two RF read addresses.
//   clk     : system clock
//   reset_n : synchronous active-low reset; while low, every output is
//             forced inactive combinationally
//   bus     : rf_write_buffer_if.slave (producers, hold, RF port, bypass,
//             empty)
// -----------------------------------------------------------------------------
module rf_write_buffer
   import rf_write_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = WORD_W,
   parameter int AW    = REG_AW
) (
   input  logic               clk,
   input  logic               reset_n,
   rf_write_buffer_if.slave   bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic      [DEPTH-1:0] valid;
   logic      [PW-1:0]    rd_ptr;
   logic      [CW-1:0]    count;

   logic drain, space, mem_rdy, ex_rdy, mem_fire, ex_fire, push;

   logic          hit  [NUM_RD_PORTS];
   logic [DW-1:0] bdat [NUM_RD_PORTS];
   logic [AW-1:0] rd_a [NUM_RD_PORTS];

   // Arbitration: MEM is the older instruction, so EX yields whenever MEM
   // is presenting. A full FIFO still accepts if the head drains this cycle.
   always_comb begin
      drain    = reset_n && (count != '0) && !bus.wb_hold;
      space    = (count < FULL_CNT) || drain;
      mem_rdy  = reset_n && space;
      ex_rdy   = reset_n && space && !bus.mem_valid;
      mem_fire = bus.mem_valid && mem_rdy;
      ex_fire  = bus.ex_valid && ex_rdy;
      push     = mem_fire || ex_fire;
      if (mem_fire) begin
         push_entry = '{addr: bus.mem_addr, data: bus.mem_data};
      end else begin
         push_entry = '{addr: bus.ex_addr, data: bus.ex_data};
      end
   end

   rf_write_buffer_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (drain),
      .head       (head),
      .entries    (entries),
      .valid      (valid),
      .rd_ptr     (rd_ptr),
      .count      (count)
   );

   // Bypass: walk slots oldest to youngest starting at the head so the last
   // match seen is the youngest. The entry draining this cycle still counts.
   always_comb begin
      rd_a[0] = bus.rd_addr1;
      rd_a[1] = bus.rd_addr2;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         hit[p]  = 1'b0;
         bdat[p] = '0;
         for (int k = 0; k < DEPTH; k++) begin
            if (reset_n && valid[rd_ptr + PW'(k)] &&
                (entries[rd_ptr + PW'(k)].addr == rd_a[p])) begin
               hit[p]  = 1'b1;
               bdat[p] = entries[rd_ptr + PW'(k)].data;
            end
         end
      end
   end

   assign bus.ex_ready  = ex_rdy;
   assign bus.mem_ready = mem_rdy;
   assign bus.rf_write  = drain;
   assign bus.rf_addr   = drain ? head.addr : '0;
   assign bus.rf_data   = drain ? head.data : '0;
   assign bus.byp_hit1  = hit[0];
   assign bus.byp_data1 = bdat[0];
   assign bus.byp_hit2  = hit[1];
   assign bus.byp_data2 = bdat[1];
   assign bus.empty     = !reset_n || (count == '0);

endmodule
